// File: rtl/mdu_ctrl.sv
// Multiply/divide unit control: same-cycle MULT/MULTU/MTHI/MTLO writes, and
// a divide sequencer driving signed/unsigned divider IPs over AXI-stream.
// Ports:
//   i_clk, i_reset (sync, active-high).
//   i_req_valid, i_req_op (one-hot {mtlo,mthi,divu,div,multu,mult}).
//   i_req_src1/i_req_src2, i_req_flush.
//   i_mul_prod: external multiplier product.
//   o_div_tvalid/o_divu_tvalid, i_div_tready/i_divu_tready.
//   o_div_dividend/o_div_divisor: latched divide operands.
//   i_div(u)_dout_tvalid, i_div(u)_dout_tdata: {quotient, remainder}.
//   o_hl_we {HI,LO}, o_h_wdata, o_l_wdata, o_stall, o_busy.
module mdu_ctrl (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    input  logic [5:0]  i_req_op,
    input  logic [31:0] i_req_src1,
    input  logic [31:0] i_req_src2,
    input  logic        i_req_flush,
    input  logic [63:0] i_mul_prod,
    output logic        o_div_tvalid,
    output logic        o_divu_tvalid,
    input  logic        i_div_tready,
    input  logic        i_divu_tready,
    output logic [31:0] o_div_dividend,
    output logic [31:0] o_div_divisor,
    input  logic        i_div_dout_tvalid,
    input  logic        i_divu_dout_tvalid,
    input  logic [63:0] i_div_dout_tdata,
    input  logic [63:0] i_divu_dout_tdata,
    output logic [1:0]  o_hl_we,
    output logic [31:0] o_h_wdata,
    output logic [31:0] o_l_wdata,
    output logic        o_stall,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_sgn;
    logic [31:0] r_dividend;
    logic [31:0] r_divisor;

    logic [5:0]  w_op;
    logic        w_go;
    logic        w_mul;
    logic        w_mthi;
    logic        w_mtlo;
    logic        w_div;
    logic        w_fast;
    logic        w_tready;
    logic        w_dvalid;
    logic [63:0] w_tdata;
    logic        w_latch;
    logic [1:0]  w_hl_we;
    logic [31:0] w_h;
    logic [31:0] w_l;
    logic        w_stall;

    // Isolate the lowest set bit so a malformed op decodes deterministically.
    assign w_op   = i_req_op & (~i_req_op + 6'd1);
    assign w_go   = i_req_valid & ~i_req_flush;
    assign w_mul  = w_go & (w_op[0] | w_op[1]);
    assign w_div  = w_go & (w_op[2] | w_op[3]);
    assign w_mthi = w_go & w_op[4];
    assign w_mtlo = w_go & w_op[5];
    // Non-divide ops may retire while a cancelled divide drains.
    assign w_fast = (r_state == S_IDLE) | (r_state == S_DRAIN);

    assign w_tready = r_sgn ? i_div_tready      : i_divu_tready;
    assign w_dvalid = r_sgn ? i_div_dout_tvalid : i_divu_dout_tvalid;
    assign w_tdata  = r_sgn ? i_div_dout_tdata  : i_divu_dout_tdata;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_sgn      <= 1'b0;
            r_dividend <= 32'd0;
            r_divisor  <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_dividend <= i_req_src1;
                r_divisor  <= i_req_src2;
                r_sgn      <= w_op[2];
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        w_hl_we = 2'b00;
        w_h     = 32'd0;
        w_l     = 32'd0;
        w_stall = 1'b0;
        if (w_fast & w_mul) begin
            w_hl_we = 2'b11;
            w_h     = i_mul_prod[63:32];
            w_l     = i_mul_prod[31:0];
        end else if (w_fast & w_mthi) begin
            w_hl_we = 2'b10;
            w_h     = i_req_src1;
            w_l     = i_req_src1;
        end else if (w_fast & w_mtlo) begin
            w_hl_we = 2'b01;
            w_h     = i_req_src1;
            w_l     = i_req_src1;
        end
        unique case (r_state)
            S_IDLE: begin
                if (w_div) begin
                    w_stall = 1'b1;
                    w_latch = 1'b1;
                    w_next  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A flush racing the handshake leaves a result in flight.
                if (i_req_flush) begin
                    w_next = w_tready ? S_DRAIN : S_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (w_tready) w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_dvalid) begin
                    w_next = S_IDLE;
                    if (w_go) begin
                        w_hl_we = 2'b11;
                        w_h     = w_tdata[31:0];
                        w_l     = w_tdata[63:32];
                    end
                end else if (i_req_flush) begin
                    w_next = S_DRAIN;
                end else begin
                    w_stall = 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_div) w_stall = 1'b1;
                if (w_dvalid) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign o_hl_we        = i_reset ? 2'b00 : w_hl_we;
    assign o_h_wdata      = i_reset ? 32'd0 : w_h;
    assign o_l_wdata      = i_reset ? 32'd0 : w_l;
    assign o_stall        = ~i_reset & w_stall;
    assign o_busy         = ~i_reset & (r_state != S_IDLE);
    assign o_div_tvalid   = ~i_reset & (r_state == S_ISSUE) & r_sgn;
    assign o_divu_tvalid  = ~i_reset & (r_state == S_ISSUE) & ~r_sgn;
    assign o_div_dividend = r_dividend;
    assign o_div_divisor  = r_divisor;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Testbench for mdu_ctrl: vector table for same-cycle ops via a scoreboard
// queue, plus hand-driven divider sequences for the multi-cycle cases.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [5:0]  req_op;
    logic [31:0] src1, src2;
    logic        flush;
    logic [63:0] mul_prod;
    logic        div_tvalid, divu_tvalid;
    logic        div_tready, divu_tready;
    logic [31:0] dividend, divisor;
    logic        div_dv, divu_dv;
    logic [63:0] div_td, divu_td;
    logic [1:0]  hl_we;
    logic [31:0] h_wdata, l_wdata;
    logic        stall, busy;

    int checks = 0;
    int failures = 0;
    int hs_div = 0;
    int hs_divu = 0;

    mdu_ctrl dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_req_valid        (req_valid),
        .i_req_op           (req_op),
        .i_req_src1         (src1),
        .i_req_src2         (src2),
        .i_req_flush        (flush),
        .i_mul_prod         (mul_prod),
        .o_div_tvalid       (div_tvalid),
        .o_divu_tvalid      (divu_tvalid),
        .i_div_tready       (div_tready),
        .i_divu_tready      (divu_tready),
        .o_div_dividend     (dividend),
        .o_div_divisor      (divisor),
        .i_div_dout_tvalid  (div_dv),
        .i_divu_dout_tvalid (divu_dv),
        .i_div_dout_tdata   (div_td),
        .i_divu_dout_tdata  (divu_td),
        .o_hl_we            (hl_we),
        .o_h_wdata          (h_wdata),
        .o_l_wdata          (l_wdata),
        .o_stall            (stall),
        .o_busy             (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && div_tvalid && div_tready) hs_div <= hs_div + 1;
        if (!reset && divu_tvalid && divu_tready) hs_divu <= hs_divu + 1;
    end

    typedef struct {
        logic        v;
        logic [5:0]  op;
        logic [31:0] s1;
        logic        fl;
        logic [63:0] prod;
        logic [1:0]  we;
        logic [31:0] h;
        logic [31:0] l;
    } vec_t;

    vec_t tbl[10];
    vec_t sb[$];
    vec_t e;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
        checks++;
        if (a !== x) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, a, x);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        req_valid = 0; req_op = 0; src1 = 0; src2 = 0; flush = 0;
        mul_prod = 0; div_tready = 0; divu_tready = 0;
        div_dv = 0; divu_dv = 0; div_td = 0; divu_td = 0;
    endtask

    task automatic req(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1; req_op = op; src1 = a; src2 = b;
    endtask

    // Full divide: accept, one ISSUE cycle with tready, 3 WAIT cycles, result.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] td, input string nm);
        int bad;
        idle;
        req(sgn ? 6'b000100 : 6'b001000, a, b);
        @(negedge clk);
        chk({nm, "_acc_stall"}, stall, 1);
        tick;
        if (sgn) div_tready = 1; else divu_tready = 1;
        @(negedge clk);
        chk({nm, "_dividend"}, dividend, a);
        chk({nm, "_divisor"}, divisor, b);
        chk({nm, "_tvalid"}, {div_tvalid, divu_tvalid}, sgn ? 2'b10 : 2'b01);
        tick;
        div_tready = 0; divu_tready = 0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (stall !== 1'b1 || hl_we !== 2'b00 || div_tvalid || divu_tvalid) bad++;
            tick;
        end
        chk({nm, "_wait"}, bad, 0);
        if (sgn) begin div_dv = 1; div_td = td; end
        else begin divu_dv = 1; divu_td = td; end
        @(negedge clk);
        chk({nm, "_we"}, hl_we, 2'b11);
        chk({nm, "_hi"}, h_wdata, td[31:0]);
        chk({nm, "_lo"}, l_wdata, td[63:32]);
        chk({nm, "_stall"}, stall, 0);
        tick;
        idle;
    endtask

    initial begin
        int hs0;
        int bad;
        idle;
        reset = 1;
        tick;
        tick;
        @(negedge clk);
        chk("rst_out", {stall, busy, hl_we, div_tvalid, divu_tvalid}, 0);
        chk("rst_data", {h_wdata, l_wdata}, 0);
        chk("rst_opnd", {dividend, divisor}, 0);
        tick;
        reset = 0;

        tbl[0] = '{1, 6'b000001, 32'hFFFFFFFE, 0, 64'hFFFFFFFF_FFFFFFFA, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFA};
        tbl[1] = '{1, 6'b000010, 32'h10, 0, 64'h00000001_00000002, 2'b11, 32'h1, 32'h2};
        tbl[2] = '{1, 6'b010000, 32'h12345678, 0, 64'h0, 2'b10, 32'h12345678, 32'h12345678};
        tbl[3] = '{1, 6'b100000, 32'hCAFEBABE, 0, 64'h0, 2'b01, 32'hCAFEBABE, 32'hCAFEBABE};
        tbl[4] = '{1, 6'b010001, 32'h0, 0, 64'hDEADBEEF_01234567, 2'b11, 32'hDEADBEEF, 32'h01234567};
        tbl[5] = '{1, 6'b110000, 32'hABCD0000, 0, 64'h0, 2'b10, 32'hABCD0000, 32'hABCD0000};
        tbl[6] = '{1, 6'b101010, 32'h0, 0, 64'h00000000_FFFFFFFF, 2'b11, 32'h0, 32'hFFFFFFFF};
        tbl[7] = '{0, 6'b000001, 32'h5, 0, 64'h5, 2'b00, 32'h0, 32'h0};
        tbl[8] = '{1, 6'b000001, 32'h5, 1, 64'h5, 2'b00, 32'h0, 32'h0};
        tbl[9] = '{1, 6'b000000, 32'h5, 0, 64'h5, 2'b00, 32'h0, 32'h0};

        for (int i = 0; i < 10; i++) begin
            req_valid = tbl[i].v; req_op = tbl[i].op;
            src1 = tbl[i].s1; src2 = 32'd3;
            flush = tbl[i].fl; mul_prod = tbl[i].prod;
            sb.push_back(tbl[i]);
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("vec%0d_we", i), hl_we, e.we);
            chk($sformatf("vec%0d_hi", i), h_wdata, e.h);
            chk($sformatf("vec%0d_lo", i), l_wdata, e.l);
            chk($sformatf("vec%0d_st", i), {stall, busy}, 2'b00);
            tick;
        end
        idle;

        // div 7/2, tready on 2nd ISSUE cycle, result after 20 cycles
        hs0 = hs_div;
        req(6'b000100, 32'd7, 32'd2);
        @(negedge clk);
        chk("d72_acc", {stall, busy, div_tvalid, hl_we}, 5'b10000);
        tick;
        div_dv = 1; div_td = 64'hFFFFFFFF_FFFFFFFF;
        @(negedge clk);
        chk("d72_iss", {busy, div_tvalid, divu_tvalid, stall, hl_we}, 6'b110100);
        chk("d72_opnd", {dividend, divisor}, {32'd7, 32'd2});
        tick;
        div_dv = 0; div_tready = 1;
        @(negedge clk);
        chk("d72_iss2", {div_tvalid, stall}, 2'b11);
        tick;
        div_tready = 0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (stall !== 1'b1 || div_tvalid !== 1'b0 || hl_we !== 2'b00) bad++;
            tick;
        end
        chk("d72_wait", bad, 0);
        div_dv = 1; div_td = 64'h00000003_00000001;
        @(negedge clk);
        chk("d72_done", {hl_we, stall}, 3'b110);
        chk("d72_hilo", {h_wdata, l_wdata}, {32'd1, 32'd3});
        tick;
        idle;
        @(negedge clk);
        chk("d72_idle", busy, 0);
        chk("d72_hs", hs_div - hs0, 1);
        tick;

        // divu flushed in ISSUE with tready low
        hs0 = hs_divu;
        req(6'b001000, 32'd9, 32'd3);
        tick;
        flush = 1;
        @(negedge clk);
        chk("fi_we", hl_we, 0);
        tick;
        idle;
        @(negedge clk);
        chk("fi_idle", {busy, divu_tvalid}, 2'b00);
        tick;
        chk("fi_hs", hs_divu - hs0, 0);

        // divu flushed in WAIT -> DRAIN; mthi and div request during DRAIN
        req(6'b001000, 32'd100, 32'd7);
        tick;
        divu_tready = 1;
        tick;
        divu_tready = 0; flush = 1;
        @(negedge clk);
        chk("dr_flush_we", hl_we, 0);
        tick;
        idle;
        req(6'b010000, 32'h12345678, 32'd0);
        @(negedge clk);
        chk("dr_mthi", {busy, hl_we, stall}, 4'b1100);
        chk("dr_mthi_d", h_wdata, 32'h12345678);
        tick;
        req(6'b000100, 32'd20, 32'd5);
        @(negedge clk);
        chk("dr_divreq", {busy, stall, div_tvalid, hl_we}, 5'b11000);
        tick;
        divu_dv = 1; divu_td = 64'h0000000E_00000002;
        @(negedge clk);
        chk("dr_discard", {hl_we, stall}, 3'b001);
        tick;
        divu_dv = 0;
        @(negedge clk);
        chk("dr_idle_acc", {busy, stall}, 2'b01);
        tick;
        div_tready = 1;
        @(negedge clk);
        chk("dr_iss", {div_tvalid, dividend, divisor}, {1'b1, 32'd20, 32'd5});
        tick;
        div_tready = 0; div_dv = 1; div_td = 64'h00000004_00000000;
        @(negedge clk);
        chk("dr_done", {hl_we, h_wdata, l_wdata}, {2'b11, 32'd0, 32'd4});
        tick;
        idle;

        // flush coinciding with tready in ISSUE -> DRAIN
        req(6'b000100, 32'd8, 32'd4);
        tick;
        div_tready = 1; flush = 1;
        tick;
        idle;
        div_dv = 1; div_td = 64'h00000002_00000000;
        @(negedge clk);
        chk("ft_drain", {busy, div_tvalid, hl_we}, 4'b1000);
        tick;
        idle;
        @(negedge clk);
        chk("ft_idle", busy, 0);
        tick;

        // result and flush coincide in WAIT
        req(6'b000100, 32'd9, 32'd2);
        tick;
        div_tready = 1;
        tick;
        div_tready = 0; flush = 1; div_dv = 1; div_td = 64'h00000004_00000001;
        @(negedge clk);
        chk("wf_we", hl_we, 0);
        tick;
        idle;
        @(negedge clk);
        chk("wf_idle", busy, 0);
        tick;

        // reset in WAIT
        req(6'b000100, 32'd50, 32'd6);
        tick;
        div_tready = 1;
        tick;
        div_tready = 0;
        tick;
        idle;
        reset = 1;
        @(negedge clk);
        chk("rw_we", hl_we, 0);
        tick;
        reset = 0;
        @(negedge clk);
        chk("rw_out", {stall, busy, hl_we, div_tvalid, divu_tvalid}, 0);
        chk("rw_data", {h_wdata, l_wdata, dividend, divisor}, 0);
        tick;
        do_div(1'b1, 32'd50, 32'd6, 64'h00000008_00000002, "rw_div");
        do_div(1'b0, 32'd5, 32'd0, 64'hFFFFFFFF_00000005, "dz_divu");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
